// File: rtl/iic_slavemod.sv
// I2C responder with an internal byte register file.
// Optional build macro IIC_SLAVEMOD_GLITCH_FILTER_EN adds a 3-sample majority
// filter on the synchronized SCL/SDA (2 extra cycles of detection latency).
module iic_slavemod #(
    parameter logic [6:0]  DEV_ADDR  = 7'b1010_000,
    parameter int unsigned MEM_DEPTH = 16
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       SCL,
    inout  wire        SDA,
    output logic [1:0] oDone,
    output logic [7:0] oAddr,
    output logic [7:0] oData,
    output logic [1:0] oTag
);

    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] DEVADR  = 4'd1;
    localparam logic [3:0] DEVACK  = 4'd2;
    localparam logic [3:0] WADR    = 4'd3;
    localparam logic [3:0] WADRACK = 4'd4;
    localparam logic [3:0] WDAT    = 4'd5;
    localparam logic [3:0] WDATACK = 4'd6;
    localparam logic [3:0] RDAT    = 4'd7;
    localparam logic [3:0] RDATACK = 4'd8;

    logic          scl_s1, scl_s2, sda_s1, sda_s2;
    logic          scl_f, sda_f, scl_p, sda_p;
    logic          scl_rise, scl_fall, start_c, stop_c;
    logic [3:0]    state, state_n;
    logic [3:0]    bitcnt, bitcnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    tx, tx_n;
    logic [AW-1:0] ptr, ptr_n;
    logic          rw, rw_n;
    logic          sda_low, sda_low_n;
    logic [1:0]    done_n, tag_n;
    logic [7:0]    addr_n, data_n;
    logic          wr_en;
    logic [7:0]    rd_byte;
    logic [7:0]    mem [MEM_DEPTH];

    // Two-flop synchronizers for the asynchronous bus lines
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= SCL;
            scl_s2 <= scl_s1;
            sda_s1 <= SDA;
            sda_s2 <= sda_s1;
        end
    end

`ifdef IIC_SLAVEMOD_GLITCH_FILTER_EN
    logic [2:0] scl_h, sda_h;

    // Three-sample history feeding the majority vote
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            scl_h <= 3'b111;
            sda_h <= 3'b111;
        end else begin
            scl_h <= {scl_h[1:0], scl_s2};
            sda_h <= {sda_h[1:0], sda_s2};
        end
    end

    assign scl_f = (scl_h[0] & scl_h[1]) | (scl_h[0] & scl_h[2]) | (scl_h[1] & scl_h[2]);
    assign sda_f = (sda_h[0] & sda_h[1]) | (sda_h[0] & sda_h[2]) | (sda_h[1] & sda_h[2]);
`else
    assign scl_f = scl_s2;
    assign sda_f = sda_s2;
`endif

    // Previous filtered values for edge and START/STOP detection
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_f;
            sda_p <= sda_f;
        end
    end

    assign scl_rise = scl_f & ~scl_p;
    assign scl_fall = ~scl_f & scl_p;
    assign start_c  = scl_f & scl_p & sda_p & ~sda_f;
    assign stop_c   = scl_f & scl_p & ~sda_p & sda_f;
    assign rd_byte  = mem[ptr];
    assign SDA      = sda_low ? 1'b0 : 1'bz;

    // Next-state and datapath decode; START/STOP override every state
    always_comb begin
        state_n   = state;
        bitcnt_n  = bitcnt;
        shreg_n   = shreg;
        tx_n      = tx;
        ptr_n     = ptr;
        rw_n      = rw;
        sda_low_n = sda_low;
        done_n    = 2'b00;
        addr_n    = oAddr;
        data_n    = oData;
        tag_n     = oTag;
        wr_en     = 1'b0;
        if (stop_c) begin
            state_n   = IDLE;
            bitcnt_n  = 4'd0;
            sda_low_n = 1'b0;
            tag_n     = 2'b00;
        end else if (start_c) begin
            state_n   = DEVADR;
            bitcnt_n  = 4'd0;
            sda_low_n = 1'b0;
            tag_n     = 2'b00;
        end else begin
            if (scl_rise && (state == DEVADR || state == WADR || state == WDAT)) begin
                shreg_n  = {shreg[6:0], sda_f};
                bitcnt_n = bitcnt + 4'd1;
            end
            case (state)
                IDLE: ;
                DEVADR: begin
                    if (scl_fall && bitcnt == 4'd8) begin
                        if (shreg[7:1] == DEV_ADDR) begin
                            state_n   = DEVACK;
                            sda_low_n = 1'b1;
                            rw_n      = shreg[0];
                            tag_n     = shreg[0] ? 2'b01 : 2'b10;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                DEVACK: begin
                    if (scl_fall) begin
                        sda_low_n = 1'b0;
                        bitcnt_n  = 4'd0;
                        if (rw) begin
                            state_n   = RDAT;
                            tx_n      = rd_byte;
                            sda_low_n = ~rd_byte[7];
                            done_n    = 2'b01;
                            addr_n    = 8'(ptr);
                            data_n    = rd_byte;
                        end else begin
                            state_n = WADR;
                        end
                    end
                end
                WADR: begin
                    if (scl_fall && bitcnt == 4'd8) begin
                        state_n   = WADRACK;
                        sda_low_n = 1'b1;
                    end
                end
                WADRACK: begin
                    if (scl_fall) begin
                        state_n   = WDAT;
                        sda_low_n = 1'b0;
                        bitcnt_n  = 4'd0;
                        ptr_n     = AW'(shreg);
                    end
                end
                WDAT: begin
                    if (scl_fall && bitcnt == 4'd8) begin
                        state_n   = WDATACK;
                        sda_low_n = 1'b1;
                        wr_en     = 1'b1;
                        done_n    = 2'b10;
                        addr_n    = 8'(ptr);
                        data_n    = shreg;
                        ptr_n     = ptr + AW'(1);
                    end
                end
                WDATACK: begin
                    if (scl_fall) begin
                        state_n   = WDAT;
                        sda_low_n = 1'b0;
                        bitcnt_n  = 4'd0;
                    end
                end
                RDAT: begin
                    if (scl_rise) begin
                        bitcnt_n = bitcnt + 4'd1;
                    end else if (scl_fall && bitcnt == 4'd8) begin
                        state_n   = RDATACK;
                        sda_low_n = 1'b0;
                        bitcnt_n  = 4'd0;
                        ptr_n     = ptr + AW'(1);
                    end else if (scl_fall && bitcnt != 4'd0) begin
                        tx_n      = {tx[6:0], 1'b0};
                        sda_low_n = ~tx[6];
                    end
                end
                RDATACK: begin
                    if (scl_rise) begin
                        if (sda_f) begin
                            state_n   = IDLE;
                            sda_low_n = 1'b0;
                            tag_n     = 2'b00;
                        end else begin
                            bitcnt_n = 4'd1;
                        end
                    end else if (scl_fall && bitcnt == 4'd1) begin
                        state_n   = RDAT;
                        bitcnt_n  = 4'd0;
                        tx_n      = rd_byte;
                        sda_low_n = ~rd_byte[7];
                        done_n    = 2'b01;
                        addr_n    = 8'(ptr);
                        data_n    = rd_byte;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, datapath and output registers
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            bitcnt  <= 4'd0;
            shreg   <= 8'd0;
            tx      <= 8'd0;
            ptr     <= '0;
            rw      <= 1'b0;
            sda_low <= 1'b0;
            oDone   <= 2'b00;
            oAddr   <= 8'd0;
            oData   <= 8'd0;
            oTag    <= 2'b00;
        end else begin
            state   <= state_n;
            bitcnt  <= bitcnt_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
            ptr     <= ptr_n;
            rw      <= rw_n;
            sda_low <= sda_low_n;
            oDone   <= done_n;
            oAddr   <= addr_n;
            oData   <= data_n;
            oTag    <= tag_n;
        end
    end

    // Register file, cleared on reset
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem[i] <= 8'd0;
            end
        end else if (wr_en) begin
            mem[ptr] <= shreg;
        end
    end

endmodule
